// File: rtl/ternary_mac_sequencer.sv
// Sequencer for the 2-lane ternary MAC datapath: weight bank, beat feed, result drain, byte stream out.
// Latency: out_valid rises OutLen+1 edges after the last-beat accept edge (counting that edge); backpressure via out_ready stalls OUT. Option: SEQ_RELU_EN.
module ternary_mac_sequencer #(
    parameter int InLen    = 14,
    parameter int OutLen   = 7,
    parameter int BitWidth = 8,
    parameter int Rows     = 8,
    localparam int RowW    = $clog2(Rows)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_we,
    input  logic [RowW-1:0]       w_addr,
    input  logic [2*InLen-1:0]    w_data,
    output logic                  w_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*BitWidth-1:0] in_data,
    output logic [RowW-1:0]       mult_row,
    output logic [2*BitWidth-1:0] mult_vec,
    output logic [2*InLen-1:0]    mult_w,
    input  logic [BitWidth-1:0]   mult_vecout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BitWidth-1:0]   out_data,
    output logic                  out_last,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t               state_q, state_d;
    logic [RowW-1:0]      cnt_q, cnt_d;
    logic                 w_err_q;
    logic [2*InLen-1:0]   bank_q [Rows];
    logic [BitWidth-1:0]  buf_q  [OutLen];
    logic                 cap_en;
    logic [BitWidth-1:0]  cap_byte;

    // One counter serves as beat index k, drain index d and output index j.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        mult_row  = '0;
        mult_vec  = '0;
        mult_w    = '0;
        cap_en    = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                mult_row = cnt_q;
                if (in_valid) begin
                    mult_vec = in_data;
                    mult_w   = bank_q[cnt_q];
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = ACCUM;
                    if (cnt_q == RowW'(Rows - 1)) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                mult_row = cnt_q;
                cap_en   = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == RowW'(OutLen - 1)) begin
                    state_d = OUT;
                    cnt_d   = '0;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                out_last  = (cnt_q == RowW'(OutLen - 1));
                if (out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (out_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SEQ_RELU_EN
    assign cap_byte = mult_vecout[BitWidth-1] ? '0 : mult_vecout;
`else
    assign cap_byte = mult_vecout;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_err_q <= 1'b0;
            for (int i = 0; i < Rows; i++) bank_q[i] <= '0;
            for (int i = 0; i < OutLen; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_err_q <= w_we && (state_q != IDLE);
            if (w_we && (state_q == IDLE)) bank_q[w_addr] <= w_data;
            if (cap_en) buf_q[cnt_q] <= cap_byte;
        end
    end

    assign w_err    = w_err_q;
    assign busy     = (state_q != IDLE);
    assign out_data = (state_q == OUT) ? buf_q[cnt_q] : '0;

endmodule

// File: doc/ternary_mac_sequencer.md
Name: ternary_mac_sequencer

Overview:
- Sequencer for the 2-lane ternary matrix-vector datapath: 8-bit accumulator per output column, ternary weights, row counter whose value 0 clears the accumulation.
- Owns an 8-entry weight bank and accepts 8 input beats (one byte pair each) per pass.
- Drives row, vector and weight slice to the datapath each cycle, then drains the OutLen result bytes into a buffer and streams them out with valid/ready.
- Sits between the host/IO shim and the datapath instance.

Parameters:
- InLen, 14, weight bits per lane per row (2 bits x OutLen).
- OutLen, 7, output columns / result bytes per pass.
- BitWidth, 8, lane and accumulator width.
- Rows, 8, beats per pass; must equal 2^(width of mult_row).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- w_we  in  1  weight bank write strobe.
- w_addr  in  3  bank entry (beat index).
- w_data  in  2*InLen  weights: bits [2c+1:2c] lane A col c; bits [InLen+2c+1:InLen+2c] lane B col c.
- w_err  out  1  one-cycle pulse: write ignored.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when valid&ready.
- in_data  in  2*BitWidth  lane A = [BitWidth-1:0], lane B = upper byte.
- mult_row  out  3  row index to datapath.
- mult_vec  out  2*BitWidth  vector to datapath.
- mult_w  out  2*InLen  weight slice to datapath.
- mult_vecout  in  BitWidth  datapath result byte selected by mult_row.
- out_valid  out  1  result byte valid.
- out_ready  in  1  downstream accept.
- out_data  out  BitWidth  result byte.
- out_last  out  1  high with final byte (column OutLen-1).
- busy  out  1  high in any state except IDLE.

Behaviour:
- Weight code per column: 2'b00 -> 0; 2'b01 -> +x; bit1 set -> -x (2'b11 treated as -x). Datapath sums are modulo 2^BitWidth (wrap, no saturation).
- Reset (async, rst_n low): state IDLE; beat counter 0; weight bank all 0; output buffer 0; in_ready=1; out_valid=0; out_last=0; w_err=0; busy=0; mult_row=0; mult_vec=0; mult_w=0. Asserting mid-pass abandons the pass; no partial output.
- Weight writes: performed only in IDLE, effective next cycle. A beat accepted in the same cycle uses the pre-write entry. w_we outside IDLE leaves the bank unchanged and pulses w_err the next cycle.
- FSM IDLE -> ACCUM -> DRAIN -> OUT -> IDLE.
- IDLE / ACCUM:
  - in_ready=1.
  - Beat k accepted: mult_row=k, mult_vec=in_data, mult_w=bank[k], combinationally in the accept cycle.
  - Counter k increments. IDLE -> ACCUM on beat 0. ACCUM -> DRAIN on accepting beat Rows-1.
- Bubble rule (no beat accepted in IDLE/ACCUM):
  - mult_row=k (next index), mult_vec=0, mult_w=0.
  - Datapath sum is held for k>0 and cleared for k=0; gaps of any length are therefore legal.
- DRAIN: exactly OutLen cycles, d=0..OutLen-1.
  - Outputs: mult_row=d, mult_vec=0, mult_w=0, in_ready=0.
  - Each cycle mult_vecout is registered into buffer[d].
  - d=0 captures the final sum: row 0 latches the datapath output.
- OUT:
  - out_valid=1; out_data=buffer[j], j=0..OutLen-1.
  - j advances on out_valid&out_ready. out_data is held stable while out_ready=0.
  - out_last=1 when j=OutLen-1; that handshake returns the FSM to IDLE and counters to 0.
  - in_ready=0 throughout.
- Latency: out_valid rises OutLen+1 clock edges after the edge accepting beat Rows-1, i.e. 8 edges with defaults.
- Throughput: one pass per Rows+OutLen+OutLen cycles minimum, i.e. 22 with defaults.

Optional Feature:
- SEQ_RELU_EN defined: each byte written into the buffer during DRAIN is clamped to 0 if its MSB is set (signed negative). Otherwise it is stored unchanged.
- Not defined: bytes are stored and emitted raw, as two's complement.

Test Plan:
- Identity pass:
  - Stimulus: all 8 entries w_data=28'h5555555; 8 beats in_data=16'h0201 back-to-back; out_ready=1.
  - Required response: 7 bytes of 8'h18; out_last on 7th byte; out_valid 8 edges after last beat.
- Negation / ReLU:
  - Stimulus: entries w_data=28'h0002AAA; 8 beats in_data=16'h0005.
  - Required response: 7 bytes of 8'hD8 (-40). With SEQ_RELU_EN: 7 bytes of 8'h00.
- Bubbles and wrap:
  - Stimulus: weights 28'h5555555; beats in_data=16'h1010 with in_valid low 3 cycles between every beat.
  - Required response: sum 8*32=256 wraps, so 7 bytes of 8'h00. Repeat with in_data=16'h0F0F for 8'hF0.
- Backpressure:
  - Stimulus: identity pass with out_ready low for 3 cycles at byte 0 and 2 cycles at byte 4.
  - Required response: out_data stable while stalled; exactly 7 handshakes; in_ready=0 until after out_last.
- Write-while-busy:
  - Stimulus: w_we with w_addr=3 during ACCUM.
  - Required response: w_err one-cycle pulse; a subsequent pass shows entry 3 unchanged.
- Reset mid-pass:
  - Stimulus: rst_n low after beat 4 of a pass.
  - Required response: all outputs at reset values; bank zeroed. A fresh pass with reloaded weights gives 8'h18 bytes (identity stimulus).
